// File: rtl/nand_resp_checker.sv
// nand_resp_checker
//   Downstream response checker for a two-input NAND cell under test. The two cell inputs
//   and the cell output are synchronized into the checker clock domain. After each input
//   change the checker waits for SETTLE_CYC quiet cycles, then compares y against ~(a & b).
//   While the inputs stay put, any movement of y is reported as a glitch.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on a_in, b_in, y_in (>= 2)
//   SETTLE_CYC   quiet cycles required before a compare (>= 1)
//   CNT_W        err_count width; the count saturates at all-ones
//
// Ports
//   clk         checker clock, rising edge
//   rst         asynchronous active-high reset
//   en          enable checking; 0 parks the FSM in idle with statistics held
//   clr         synchronous clear of all statistics, wins over en
//   a_in, b_in  NAND inputs (asynchronous)
//   y_in        NAND output (asynchronous)
//   check_stb   1-cycle pulse per compare
//   err_pulse   1-cycle pulse per mismatch or glitch
//   err_sticky  set by the first error, cleared by rst/clr
//   err_count   saturating error count
//   fail_vec    {a,b,y} of the first error
//   cov_mask    bit {a,b} set when that combination passes a compare
//   cov_done    all four combinations covered
module nand_resp_checker #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             y_in,
    output logic             check_stb,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       fail_vec,
    output logic [3:0]       cov_mask,
    output logic             cov_done
);

    localparam int unsigned     SCW         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StStable} state_t;

    state_t                 state_q;
    logic [SCW-1:0]         settle_cnt_q;
    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic [SYNC_STAGES-1:0] y_sync_q;
    logic [1:0]             ab_prev_q;
    logic                   y_prev_q;

    logic       a_s;
    logic       b_s;
    logic       y_s;
    logic [1:0] ab_s;
    logic       in_change;
    logic       y_change;
    logic       mismatch;
    logic       is_check;
    logic       is_glitch;
    logic       err_evt;

    // Synchronizers plus one-cycle history used for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync_q  <= '0;
            b_sync_q  <= '0;
            y_sync_q  <= '0;
            ab_prev_q <= 2'b00;
            y_prev_q  <= 1'b0;
        end else begin
            a_sync_q  <= {a_sync_q[SYNC_STAGES-2:0], a_in};
            b_sync_q  <= {b_sync_q[SYNC_STAGES-2:0], b_in};
            y_sync_q  <= {y_sync_q[SYNC_STAGES-2:0], y_in};
            ab_prev_q <= ab_s;
            y_prev_q  <= y_s;
        end
    end

    assign a_s       = a_sync_q[SYNC_STAGES-1];
    assign b_s       = b_sync_q[SYNC_STAGES-1];
    assign y_s       = y_sync_q[SYNC_STAGES-1];
    assign ab_s      = {a_s, b_s};
    assign in_change = (ab_s != ab_prev_q);
    assign y_change  = (y_s != y_prev_q);
    assign mismatch  = (y_s != ~(a_s & b_s));
    assign is_check  = (state_q == StCheck);
    // An input change in the same cycle explains the y movement, so it is not a glitch.
    assign is_glitch = (state_q == StStable) && !in_change && y_change;
    assign err_evt   = (is_check && mismatch) || is_glitch;
    assign cov_done  = &cov_mask;

    // FSM with registered strobes and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            check_stb    <= 1'b0;
            err_pulse    <= 1'b0;
            err_sticky   <= 1'b0;
            err_count    <= '0;
            fail_vec     <= 3'b000;
            cov_mask     <= 4'b0000;
        end else begin
            check_stb <= 1'b0;
            err_pulse <= 1'b0;
            if (clr) begin
                state_q      <= StIdle;
                settle_cnt_q <= '0;
                err_sticky   <= 1'b0;
                err_count    <= '0;
                fail_vec     <= 3'b000;
                cov_mask     <= 4'b0000;
            end else begin
                // Compares and glitches are recorded even in the cycle en drops.
                if (is_check) begin
                    check_stb <= 1'b1;
                    if (!mismatch) begin
                        cov_mask[ab_s] <= 1'b1;
                    end
                end
                if (err_evt) begin
                    err_pulse  <= 1'b1;
                    err_sticky <= 1'b1;
                    if (err_count != CNT_MAX) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (!err_sticky) begin
                        fail_vec <= {ab_s, y_s};
                    end
                end

                if (!en) begin
                    state_q <= StIdle;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            state_q      <= StSettle;
                            settle_cnt_q <= '0;
                        end
                        StSettle: begin
                            if (in_change) begin
                                settle_cnt_q <= '0;
                            end else if (settle_cnt_q == SETTLE_LAST) begin
                                state_q <= StCheck;
                            end else begin
                                settle_cnt_q <= settle_cnt_q + 1'b1;
                            end
                        end
                        StCheck: begin
                            state_q <= StStable;
                        end
                        StStable: begin
                            if (in_change) begin
                                state_q      <= StSettle;
                                settle_cnt_q <= '0;
                            end
                        end
                        default: begin
                            state_q <= StIdle;
                        end
                    endcase
                end
            end
        end
    end

endmodule
